seq_restoring_divider: RTL and testbench
========================================

# seq_restoring_divider

Iterative unsigned restoring divider, the inverse operation of the team's partial-product multiplier blocks. It accepts an N-bit dividend and divisor over a valid/ready handshake and computes one quotient bit per clock. It returns quotient, remainder and a divide-by-zero flag over a second valid/ready handshake. It sits beside the generated multipliers as the division datapath and serves as a round-trip checker (P = A*B, then P / B == A, remainder 0).

## Interface
- N, default 4: operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk by the system.
- in_valid  input  1  dividend/divisor valid.
- in_ready  output  1  block can accept an operation.
- dividend  input  N  unsigned dividend.
- divisor  input  N  unsigned divisor.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quotient  output  N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  result came from a zero divisor.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, step counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register dividend and divisor.
  - Divisor==0: load quotient={N{1}}, remainder=dividend, div_by_zero=1, and go to DONE.
  - Otherwise: clear the working remainder (N+1 bits), load the shift register with dividend, clear div_by_zero, clear the counter, and go to CALC.
- CALC, one restoring step per cycle:
  - Shift {rem, q} left by 1, bringing the dividend MSB into the rem LSB.
  - Form trial = rem_shifted - {1'b0, divisor} at N+1 bits.
  - If the trial MSB is 0: rem = trial and the new q LSB = 1. Otherwise keep rem_shifted and set q LSB = 0.
  - The counter increments each step. After step N (counter==N-1), write quotient/remainder outputs and go to DONE.
- DONE:
  - out_valid=1 and in_ready=0.
  - Outputs are stable while out_valid && !out_ready.
  - On out_valid&&out_ready, go to IDLE.
- quotient, remainder and div_by_zero hold the last result after the handshake until the next result is written.
- in_ready is 0 in CALC and DONE. No new operation is accepted until the result handshake completes. Inputs are ignored outside IDLE.
- Invariant for divisor!=0: quotient*divisor + remainder == dividend, and remainder < divisor.
- Reset mid-operation: an immediate return to the reset state. The partial result is discarded and out_valid never asserts for that operation.

## Timing
- Edge 0 is the accepting edge (in_valid&&in_ready sampled high).
- Normal divide: CALC occupies edges 1..N. out_valid is high after edge N, so latency from accept to out_valid is N cycles.
- Zero divisor: out_valid is high after edge 1.
- Result handshake at edge k: out_valid=0 and in_ready=1 after edge k. The earliest next accept is edge k+1.
- Minimum issue interval is N+2 cycles with out_ready held high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- N=4, dividend=13, divisor=3, out_ready=1 -> out_valid 4 cycles after accept; quotient=4, remainder=1, div_by_zero=0.
- N=4, dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=2, divisor=9 -> quotient=0, remainder=2.
- N=4, dividend=7, divisor=0 -> out_valid 1 cycle after accept; quotient=15, remainder=7, div_by_zero=1.
- Backpressure: 13/3 with out_ready low for 5 cycles after out_valid -> quotient=4 and remainder=1 stable, in_ready=0 throughout, and in_valid pulses with other operands ignored. After out_ready goes high, in_ready=1 the next cycle.
- Reset mid-CALC: assert rst_n=0 two cycles after accepting 9/2 -> all outputs at reset values immediately, no out_valid. A subsequent 9/2 -> quotient=4, remainder=1.
- Exhaustive N=4: all 256 dividend/divisor pairs, back-to-back with random out_ready -> every result matches the division model (zero-divisor rule included), and latency is exactly N (or 1) cycles each time.

Source files
------------

// File: rtl/seq_restoring_divider_if.sv
// Handshake bundle for the restoring divider: operand request channel and result channel.
interface seq_restoring_divider_if #(
    parameter int unsigned N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output in_valid,
        output dividend,
        output divisor,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  in_valid,
        input  dividend,
        input  divisor,
        input  out_ready,
        output in_ready,
        output out_valid,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, registered outputs.
module seq_restoring_divider #(
    parameter int unsigned N = 4
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    seq_restoring_divider_if.slave s_bus
);
    localparam int unsigned CntW = $clog2(N);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          r_state;
    logic [N:0]      r_rem;
    logic [N-1:0]    r_q;
    logic [N-1:0]    r_divisor;
    logic [CntW-1:0] r_cnt;
    logic            r_in_ready;
    logic            r_out_valid;
    logic [N-1:0]    r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_dbz;

    logic [N:0]      w_rem_shift;
    logic [N:0]      w_trial;
    logic            w_fits;
    logic [N-1:0]    w_q_next;
    logic [N:0]      w_rem_next;

    always_comb begin
        w_rem_shift = {r_rem[N-1:0], r_q[N-1]};
        w_trial     = w_rem_shift - {1'b0, r_divisor};
        w_fits      = ~w_trial[N];
        w_q_next    = {r_q[N-2:0], w_fits};
        w_rem_next  = w_fits ? w_trial : w_rem_shift;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (s_bus.in_valid && r_in_ready) begin
                        r_divisor  <= s_bus.divisor;
                        r_in_ready <= 1'b0;
                        r_cnt      <= '0;
                        if (s_bus.divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= s_bus.dividend;
                            r_dbz       <= 1'b1;
                            r_state     <= StDone;
                        end else begin
                            r_rem   <= '0;
                            r_q     <= s_bus.dividend;
                            r_dbz   <= 1'b0;
                            r_state <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CntW'(1);
                    if (r_cnt == CntW'(N - 1)) begin
                        r_quotient  <= w_q_next;
                        r_remainder <= w_rem_next[N-1:0];
                        r_out_valid <= 1'b1;
                        r_state     <= StDone;
                    end
                end
                StDone: begin
                    // Zero-divisor path enters here with out_valid still low; raise it one cycle later.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (s_bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign s_bus.in_ready    = r_in_ready;
    assign s_bus.out_valid   = r_out_valid;
    assign s_bus.quotient    = r_quotient;
    assign s_bus.remainder   = r_remainder;
    assign s_bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and exhaustive self-checking bench for seq_restoring_divider at N=4.
module tb_seq_restoring_divider;
    localparam int unsigned N = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seq_restoring_divider_if #(.N(N)) bus ();

    seq_restoring_divider #(.N(N)) u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .s_bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, measure latency, then complete the result handshake.
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic [N-1:0] eq, input logic [N-1:0] er,
                          input logic edbz, input int elat, input logic rand_ready);
        int   guard;
        int   lat;
        logic rdy;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        tick();
        bus.in_valid = 1'b0;
        check("in_ready_after_accept", 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (lat < 20) begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            lat++;
            if (bus.out_valid) break;
        end
        check("latency", 32'(lat), 32'(elat));
        check("quotient", 32'(bus.quotient), 32'(eq));
        check("remainder", 32'(bus.remainder), 32'(er));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(edbz));
        guard = 0;
        do begin
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rdy;
            tick();
            guard++;
            if (!rdy) begin
                check("hold_out_valid", 32'(bus.out_valid), 32'd1);
                check("hold_quotient", 32'(bus.quotient), 32'(eq));
            end
        end while (!rdy && guard < 30);
        check("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        check("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        check("post_hs_quotient_hold", 32'(bus.quotient), 32'(eq));
    endtask

    initial begin
        int lat;
        logic [N-1:0] eq;
        logic [N-1:0] er;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_quotient", 32'(bus.quotient), 32'd0);
        check("rst_remainder", 32'(bus.remainder), 32'd0);
        check("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        #10 rst_n = 1'b1;
        tick();

        run_op(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 4, 1'b0);
        run_op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 4, 1'b0);
        run_op(4'd2, 4'd9, 4'd0, 4'd2, 1'b0, 4, 1'b0);
        run_op(4'd7, 4'd0, 4'd15, 4'd7, 1'b1, 1, 1'b0);
        run_op(4'd14, 4'd14, 4'd1, 4'd0, 1'b0, 4, 1'b0);

        // Backpressure: 13/3 held for 5 cycles while a foreign request is offered.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.dividend  = 4'd13;
        bus.divisor   = 4'd3;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (bus.out_valid) break;
        end
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.dividend = 4'd7;
            bus.divisor  = 4'd2;
            tick();
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_quotient", 32'(bus.quotient), 32'd4);
            check("bp_remainder", 32'(bus.remainder), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        check("bp_no_foreign_accept", 32'(bus.in_ready), 32'd1);

        // Reset two cycles into a 9/2 calculation.
        bus.in_valid = 1'b1;
        bus.dividend = 4'd9;
        bus.divisor  = 4'd2;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_quotient", 32'(bus.quotient), 32'd0);
        check("mid_rst_remainder", 32'(bus.remainder), 32'd0);
        check("mid_rst_dbz", 32'(bus.div_by_zero), 32'd0);
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mid_rst_no_out_valid", 32'(bus.out_valid), 32'd0);
        end
        run_op(4'd9, 4'd2, 4'd4, 4'd1, 1'b0, 4, 1'b0);

        // Exhaustive sweep, back-to-back with random out_ready.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                eq = (b == 0) ? 4'hF : 4'(a / b);
                er = (b == 0) ? 4'(a) : 4'(a % b);
                run_op(4'(a), 4'(b), eq, er, 1'(b == 0), (b == 0) ? 1 : 4, 1'b1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
